ahb_slave_arbiter: RTL and testbench
====================================

Name: ahb_slave_arbiter

Overview:
- Per-slave-port arbiter for the 4-master AHB-Lite matrix.
- Decides which master owns the address phase of one slave and drives the address-phase and data-phase selects of that slave's master-to-slave mux.
- Selection rules: round-robin or fixed priority, with burst and HMASTLOCK hold and HREADY-qualified handover.
- One instance per slave port, placed beside the port's m2s mux.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (M0 highest, M3 lowest).
- PARK_MASTER, 0, master index (0-3) selected after reset and while no request is pending.

Ports:
- HCLK  in  1  system clock; all state changes on the rising edge.
- HRESET  in  1  synchronous reset, active-high.
- M_REQ  in  4  bit i: master i addresses this slave (decoded HSEL and HTRANS[1]).
- HTRANS  in  2  HTRANS at the mux output (current owner).
- HBURST  in  3  HBURST at the mux output.
- HMASTLOCK  in  1  HMASTLOCK at the mux output.
- HREADY  in  1  HREADYOUT from the slave; a transfer is accepted when HREADY=1.
- Master_Sel_A  out  2  address-phase select for the m2s mux.
- Master_Sel_D  out  2  data-phase select for the m2s mux.
- GRANT  out  4  one-hot decode of Master_Sel_A.

Behaviour:
- Reset:
  - Master_Sel_A = Master_Sel_D = PARK_MASTER; GRANT = one-hot(PARK_MASTER).
  - FSM = FREE; beat counter = 0; round-robin pointer = PARK_MASTER.
- Master_Sel_D: loads Master_Sel_A on every edge where HREADY=1; otherwise holds. Lags Sel_A by exactly one accepted address phase.
- Master_Sel_A: changes only on an edge where HREADY=1 and the FSM permits handover. It never changes while HREADY=0.
- FSM states:
  - FREE: owner may be replaced.
  - BURST: fixed-length burst in progress.
  - INCR: undefined-length burst in progress.
  - LOCK: locked sequence.
- Burst encoding: HBURST 000 = SINGLE; 001 = INCR; 010/011 = WRAP4/INCR4; 100/101 = WRAP8/INCR8; 110/111 = WRAP16/INCR16.
- Transitions, evaluated only when HREADY=1:
  - Any state, HMASTLOCK=1 and HTRANS != IDLE -> LOCK. Lock has top precedence.
  - FREE, NONSEQ with 4/8/16-beat burst -> BURST; beat counter = beats-1 (3/7/15).
  - FREE, NONSEQ with INCR -> INCR.
  - BURST, SEQ -> counter decrements. On the edge that accepts the SEQ with counter==1, go to FREE; the handover takes effect on that same edge.
  - BURST, BUSY -> no decrement, hold.
  - INCR, IDLE or NONSEQ -> FREE; NONSEQ+INCR re-enters INCR for the same owner.
  - INCR, M_REQ[owner]=0 -> FREE.
  - LOCK, HMASTLOCK=0 and HTRANS in {IDLE, NONSEQ} -> FREE.
- Handover in FREE, HREADY=1, at least one M_REQ bit set:
  - The winner becomes Master_Sel_A on the next edge.
  - Round-robin: search starts at pointer+1 mod 4; the pointer updates to the winner. The current owner may win again only if no other master requests.
  - Fixed priority: lowest requesting index wins.
  - The edge that loads a new owner applies no FSM transition for the previous owner; the new owner's first NONSEQ is evaluated on its first accepted cycle.
- No request in FREE: Master_Sel_A = PARK_MASTER (parking). The pointer is not updated.
- Handover while the current owner itself presents NONSEQ SINGLE: allowed. That transfer is still accepted because the handover takes effect only after the edge.
- Reset mid-burst: returns to the reset values on the next edge; no beat completion is required.
- The counter is 4 bits and never wraps below 0. A SEQ arriving in FREE is treated as SINGLE, an erroneous master.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HBURST codes.
  - A beats-per-burst function.
  - FSM state encoding.
- Natural sub-module: rr_pick4, a combinational 4-way round-robin/fixed-priority picker with pointer input. Reused by other slave ports.

Test Plan:
- Reset, no requests: after reset M_REQ=0 for 5 cycles -> Sel_A=Sel_D=0, GRANT=0001 throughout.
- INCR4 burst blocks handover: M_REQ=0011, M0 issues NONSEQ INCR4 then 3 SEQ with HREADY=1 -> Sel_A=0 for all 4 beats, becomes 1 on the edge accepting the 4th beat; Sel_D becomes 1 one accepted cycle later.
- Wait states: slave holds HREADY=0 for 3 cycles during M1 beat 2 -> Sel_A and Sel_D frozen, counter unchanged.
- Round-robin fairness: PRIORITY_MODE=0, all masters request SINGLE continuously -> Sel_A sequence 0,1,2,3,0.
- Fixed priority: PRIORITY_MODE=1, same stimulus -> Sel_A stays 0.
- Lock and reset: M2 locked SINGLE x3 with M_REQ=1111 -> Sel_A stays 2 until the HMASTLOCK=0 IDLE cycle. Assert HRESET mid-INCR8 -> next edge Sel_A=PARK_MASTER, FSM FREE.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite codes, burst length helper and arbiter state encoding
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_BURST = 2'd1,
        ST_INCR  = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_e;

    // Beats in a fixed-length burst; SINGLE and INCR report 1.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst[2:1])
            2'b01:   burst_beats = 5'd4;
            2'b10:   burst_beats = 5'd8;
            2'b11:   burst_beats = 5'd16;
            default: burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin / fixed-priority picker
module rr_pick4 (
    input  logic       fixed_prio_i,
    input  logic [1:0] ptr_i,
    input  logic [3:0] req_i,
    output logic       valid_o,
    output logic [1:0] pick_o
);

    logic [1:0] cand;

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        valid_o = |req_i;
        pick_o  = ptr_i;
        cand    = ptr_i;
        if (fixed_prio_i) begin
            for (int k = 3; k >= 0; k--) begin
                if (req_i[k]) pick_o = 2'(k);
            end
        end else begin
            // k=4 wraps to the pointer itself: the last holder ranks lowest.
            for (int k = 4; k >= 1; k--) begin
                cand = ptr_i + 2'(k);
                if (req_i[cand]) pick_o = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - per-slave-port address/data phase owner arbiter
module ahb_slave_arbiter
    import ahb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int PARK_MASTER   = 0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] M_REQ,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HMASTLOCK,
    input  logic       HREADY,
    output logic [1:0] Master_Sel_A,
    output logic [1:0] Master_Sel_D,
    output logic [3:0] GRANT
);

    localparam logic [1:0] PARK = PARK_MASTER[1:0];

    arb_state_e state_q, state_d;
    arb_state_e start_state;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] start_cnt;
    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_d_q, sel_d_d;
    logic [1:0] ptr_q, ptr_d;
    logic       pick_valid;
    logic [1:0] pick;

    rr_pick4 u_pick (
        .fixed_prio_i (PRIORITY_MODE != 0),
        .ptr_i        (ptr_q),
        .req_i        (M_REQ),
        .valid_o      (pick_valid),
        .pick_o       (pick)
    );

    // State register: everything returns to the park master on reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_FREE;
            cnt_q   <= 4'd0;
            sel_a_q <= PARK;
            sel_d_q <= PARK;
            ptr_q   <= PARK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_a_q <= sel_a_d;
            sel_d_q <= sel_d_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: evaluate the owner's accepted transfer, then hand over if free.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_a_d     = sel_a_q;
        sel_d_d     = sel_d_q;
        ptr_d       = ptr_q;
        start_state = ST_FREE;
        start_cnt   = 4'd0;

        // What a NONSEQ opens; SEQ/BUSY/IDLE outside a burst behave as SINGLE.
        if (HTRANS == HTRANS_NONSEQ) begin
            if (HBURST == HBURST_INCR) begin
                start_state = ST_INCR;
            end else if (HBURST != HBURST_SINGLE) begin
                start_state = ST_BURST;
                start_cnt   = 4'(burst_beats(HBURST) - 5'd1);
            end
        end

        if (HREADY) begin
            sel_d_d = sel_a_q;
            if (HMASTLOCK && (HTRANS != HTRANS_IDLE)) begin
                state_d = ST_LOCK;
                cnt_d   = 4'd0;
            end else begin
                case (state_q)
                    ST_FREE: begin
                        state_d = start_state;
                        cnt_d   = start_cnt;
                    end
                    ST_BURST: begin
                        if ((HTRANS == HTRANS_SEQ) && (cnt_q != 4'd0)) begin
                            cnt_d = cnt_q - 4'd1;
                            if (cnt_q == 4'd1) state_d = ST_FREE;
                        end
                    end
                    ST_INCR: begin
                        if (!M_REQ[sel_a_q] || (HTRANS == HTRANS_IDLE)) begin
                            state_d = ST_FREE;
                        end else if (HTRANS == HTRANS_NONSEQ) begin
                            state_d = start_state;
                            cnt_d   = start_cnt;
                        end
                    end
                    ST_LOCK: begin
                        if (!HMASTLOCK && (HTRANS == HTRANS_IDLE)) begin
                            state_d = ST_FREE;
                        end else if (!HMASTLOCK && (HTRANS == HTRANS_NONSEQ)) begin
                            state_d = start_state;
                            cnt_d   = start_cnt;
                        end
                    end
                    default: state_d = ST_FREE;
                endcase
            end

            if (state_d == ST_FREE) begin
                if (pick_valid) begin
                    sel_a_d = pick;
                    ptr_d   = pick;
                end else begin
                    sel_a_d = PARK;
                end
            end
        end
    end

    // Outputs: mux selects straight from registers, GRANT decoded from Sel_A.
    always_comb begin
        Master_Sel_A = sel_a_q;
        Master_Sel_D = sel_d_q;
        GRANT        = 4'b0001 << sel_a_q;
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb/tb_ahb_slave_arbiter.sv - self-checking bench for ahb_slave_arbiter
module tb_ahb_slave_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] M_REQ;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HMASTLOCK;
    logic       HREADY;

    logic [1:0] sa0, sd0, sa1, sd1;
    logic [3:0] gr0, gr1;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b0;

    // instance 0: round-robin, park 0; instance 1: fixed priority, park 2
    int  m_owner[2], m_dsel[2], m_ptr[2], m_left[2];
    bit  m_incr[2], m_lock[2];

    ahb_slave_arbiter #(.PRIORITY_MODE(0), .PARK_MASTER(0)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .M_REQ(M_REQ), .HTRANS(HTRANS),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .Master_Sel_A(sa0), .Master_Sel_D(sd0), .GRANT(gr0)
    );

    ahb_slave_arbiter #(.PRIORITY_MODE(1), .PARK_MASTER(2)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET), .M_REQ(M_REQ), .HTRANS(HTRANS),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .Master_Sel_A(sa1), .Master_Sel_D(sd1), .GRANT(gr1)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [3:0] act, input int exp);
        n_checks++;
        if (act !== 4'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A NONSEQ opens a burst/INCR run; anything else leaves the bus free.
    task automatic open_xfer(input int i, output bit rel);
        rel = 1'b1;
        if (HTRANS == 2'b10 && HBURST == 3'b001) begin
            m_incr[i] = 1'b1;
            rel = 1'b0;
        end else if (HTRANS == 2'b10 && HBURST >= 3'b010) begin
            m_left[i] = (2 << (int'(HBURST) / 2)) - 1;
            rel = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit rel;
        int park, c;
        park = (i == 0) ? 0 : 2;
        if (HRESET) begin
            m_owner[i] = park; m_dsel[i] = park; m_ptr[i] = park;
            m_left[i] = 0; m_incr[i] = 0; m_lock[i] = 0;
            return;
        end
        if (!HREADY) return;
        m_dsel[i] = m_owner[i];
        rel = 1'b0;
        if (HMASTLOCK && HTRANS != 2'b00) begin
            m_lock[i] = 1; m_left[i] = 0; m_incr[i] = 0;
        end else if (m_lock[i]) begin
            if (!HMASTLOCK && (HTRANS == 2'b00 || HTRANS == 2'b10)) begin
                m_lock[i] = 0;
                open_xfer(i, rel);
            end
        end else if (m_left[i] > 0) begin
            if (HTRANS == 2'b11) begin
                m_left[i]--;
                rel = (m_left[i] == 0);
            end
        end else if (m_incr[i]) begin
            if (!M_REQ[m_owner[i]] || HTRANS == 2'b00) begin
                m_incr[i] = 0; rel = 1'b1;
            end else if (HTRANS == 2'b10) begin
                m_incr[i] = 0;
                open_xfer(i, rel);
            end
        end else begin
            open_xfer(i, rel);
        end
        if (rel) begin
            if (M_REQ == 4'b0000) begin
                m_owner[i] = park;
            end else if (i == 1) begin
                c = 0;
                while (!M_REQ[c]) c++;
                m_owner[i] = c;
                m_ptr[i] = c;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr[i] + k) % 4;
                    if (M_REQ[c]) begin
                        m_owner[i] = c;
                        break;
                    end
                end
                m_ptr[i] = m_owner[i];
            end
        end
    endtask

    always @(posedge HCLK) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("rr_sel_a", sa0, m_owner[0]);
            check("rr_sel_d", sd0, m_dsel[0]);
            check("rr_grant", gr0, 1 << m_owner[0]);
            check("fp_sel_a", sa1, m_owner[1]);
            check("fp_sel_d", sd1, m_dsel[1]);
            check("fp_grant", gr1, 1 << m_owner[1]);
        end
    end

    task automatic cyc(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                       input logic lk, input logic rdy);
        M_REQ = req; HTRANS = tr; HBURST = bu; HMASTLOCK = lk; HREADY = rdy;
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1'b1; M_REQ = 4'b0; HTRANS = 2'b00; HBURST = 3'b000;
        HMASTLOCK = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        chk_en = 1'b1;
        check("lit_reset_rr_sel_a", sa0, 0);
        check("lit_reset_rr_grant", gr0, 4'b0001);
        check("lit_reset_fp_sel_a", sa1, 2);
        check("lit_reset_fp_grant", gr1, 4'b0100);
        HRESET = 1'b0;

        // idle: parked on M0
        repeat (5) begin
            cyc(4'b0000, 2'b00, 3'b000, 0, 1);
            check("lit_park_sel_a", sa0, 0);
            check("lit_park_sel_d", sd0, 0);
            check("lit_park_grant", gr0, 4'b0001);
        end

        // M0 INCR4 blocks M1 until the 4th beat is accepted
        cyc(4'b0011, 2'b10, 3'b011, 0, 1);
        check("lit_incr4_b1", sa0, 0);
        repeat (2) begin
            cyc(4'b0011, 2'b11, 3'b011, 0, 1);
            check("lit_incr4_b23", sa0, 0);
        end
        cyc(4'b0011, 2'b11, 3'b011, 0, 1);
        check("lit_incr4_hand_a", sa0, 1);
        check("lit_incr4_hand_d", sd0, 0);

        // M1 INCR4 with 3 wait states on beat 2
        cyc(4'b0011, 2'b10, 3'b011, 0, 1);
        check("lit_m1_b1_a", sa0, 1);
        check("lit_m1_b1_d", sd0, 1);
        repeat (3) begin
            cyc(4'b0011, 2'b11, 3'b011, 0, 0);
            check("lit_wait_a", sa0, 1);
            check("lit_wait_d", sd0, 1);
        end
        repeat (2) begin
            cyc(4'b0011, 2'b11, 3'b011, 0, 1);
            check("lit_m1_b23", sa0, 1);
        end
        cyc(4'b0011, 2'b11, 3'b011, 0, 1);
        check("lit_m1_b4_hand", sa0, 0);

        // everyone requests SINGLE: RR rotates, fixed priority sticks to M0
        for (int k = 0; k < 4; k++) begin
            cyc(4'b1111, 2'b10, 3'b000, 0, 1);
            check("lit_rr_seq", sa0, (k + 1) % 4);
            check("lit_fp_seq", sa1, 0);
        end

        // M2 locked sequence
        cyc(4'b0100, 2'b00, 3'b000, 0, 1);
        check("lit_lock_take", sa0, 2);
        repeat (3) begin
            cyc(4'b1111, 2'b10, 3'b000, 1, 1);
            check("lit_lock_hold", sa0, 2);
        end
        cyc(4'b1111, 2'b00, 3'b000, 0, 1);
        check("lit_lock_release", sa0, 3);

        // reset in the middle of an M3 INCR8
        cyc(4'b1000, 2'b10, 3'b101, 0, 1);
        check("lit_incr8_b1", sa0, 3);
        repeat (2) begin
            cyc(4'b1111, 2'b11, 3'b101, 0, 1);
            check("lit_incr8_hold", sa0, 3);
        end
        HRESET = 1'b1;
        cyc(4'b1111, 2'b11, 3'b101, 0, 1);
        check("lit_midreset_rr_a", sa0, 0);
        check("lit_midreset_rr_d", sd0, 0);
        check("lit_midreset_fp_a", sa1, 2);
        HRESET = 1'b0;
        cyc(4'b0011, 2'b10, 3'b000, 0, 1);
        check("lit_after_reset_free", sa0, 1);

        // undefined-length INCR ends when the owner drops its request
        cyc(4'b0010, 2'b10, 3'b001, 0, 1);
        check("lit_incr_start", sa0, 1);
        repeat (2) begin
            cyc(4'b0011, 2'b11, 3'b001, 0, 1);
            check("lit_incr_hold", sa0, 1);
        end
        cyc(4'b0001, 2'b00, 3'b001, 0, 1);
        check("lit_incr_end", sa0, 0);

        // parking leaves the pointer alone; stray SEQ in FREE acts as SINGLE
        cyc(4'b0100, 2'b00, 3'b000, 0, 1);
        check("lit_to_m2", sa0, 2);
        cyc(4'b0000, 2'b00, 3'b000, 0, 1);
        check("lit_repark_a", sa0, 0);
        check("lit_repark_d", sd0, 2);
        cyc(4'b0110, 2'b11, 3'b000, 0, 1);
        check("lit_ptr_kept", sa0, 1);

        repeat (2) cyc(4'b0000, 2'b00, 3'b000, 0, 1);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
